fft_out_serializer: RTL

Output back-end of the 8-point FFT pipeline. Captures one complete 8-bin result frame from the final butterfly stage in a single cycle. Bins arrive in bit-reversed slot order. The block reorders them to natural frequency order and streams them one bin per transfer over a valid/ready interface. Two frame banks (ping-pong) let the pipeline deliver a new frame while the previous one drains.

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_frame_bank.sv | 35 +++
 rtl/fft_out_serializer.sv | 96 +++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point FFT pipeline.
package fft_pkg;
  localparam int FFT_POINTS = 8;
  localparam int IDX_W      = 3;

  function automatic int word_w(input int n);
    return 1 << n;
  endfunction

  // Bit-reversal of a 3-bit slot index: 1<->4, 3<->6, others fixed.
  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] j);
    return {j[0], j[1], j[2]};
  endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// One 8-bin re/im frame register: parallel bit-reversed write, indexed read.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [FFT_POINTS*W-1:0] wr_re_i,
  input  logic [FFT_POINTS*W-1:0] wr_im_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [W-1:0]            rd_re_o,
  output logic [W-1:0]            rd_im_o
);
  logic [FFT_POINTS-1:0][W-1:0] re_q;
  logic [FFT_POINTS-1:0][W-1:0] im_q;

  // Entry k holds bin X[k], taken from slot bitrev3(k) of the input frame.
  for (genvar k = 0; k < FFT_POINTS; k++) begin : g_bin
    localparam int SLOT = int'(bitrev3(IDX_W'(k)));
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end else if (wr_en_i) begin
        re_q[k] <= wr_re_i[SLOT*W +: W];
        im_q[k] <= wr_im_i[SLOT*W +: W];
      end
    end
  end

  assign rd_re_o = re_q[rd_idx_i];
  assign rd_im_o = im_q[rd_idx_i];
endmodule

// File: rtl/fft_out_serializer.sv
// FFT output back-end: ping-pong frame capture, natural-order bin streaming.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int N = 4,
  localparam int W = word_w(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FFT_POINTS*W-1:0] in_re,
  input  logic [FFT_POINTS*W-1:0] in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_re,
  output logic [W-1:0]            out_im,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    overflow
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 1);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             ovf_q, ovf_d;

  logic             accept, xfer;
  logic [1:0]       bank_we;
  logic [1:0][W-1:0] bank_re, bank_im;

  assign in_ready  = !full_q[wr_bank_q];
  assign accept    = in_valid && in_ready;
  assign out_valid = full_q[rd_bank_q];
  assign xfer      = out_valid && out_ready;
  assign bank_we   = {accept && wr_bank_q, accept && !wr_bank_q};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.W(W)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (bank_we[b]),
      .wr_re_i  (in_re),
      .wr_im_i  (in_im),
      .rd_idx_i (rd_idx_q),
      .rd_re_o  (bank_re[b]),
      .rd_im_o  (bank_im[b])
    );
  end

  assign out_re   = bank_re[rd_bank_q];
  assign out_im   = bank_im[rd_bank_q];
  assign out_idx  = rd_idx_q;
  assign out_last = out_valid && (rd_idx_q == LAST_IDX);
  assign overflow = ovf_q;

  // Accept only targets an empty bank and the final transfer only a full one,
  // so both can update full_d on the same edge without colliding.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    ovf_d     = ovf_q;
    if (accept) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    if (xfer) begin
      rd_idx_d = rd_idx_q + IDX_W'(1);
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
    if (in_valid && !in_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      ovf_q     <= ovf_d;
    end
  end
endmodule
